key_debounce_4: RTL

Four-channel push-button front end. It synchronises the raw active-low key pins, debounces each channel with its own state machine, and produces a clean level, one-cycle press and release pulses, and a one-shot long-press pulse per key. It is the input side of the board I/O, pairing with the LED output drivers, and feeds mode and speed control logic with glitch-free events.

---
 rtl/key_debounce_4_if.sv | 25 ++
 rtl/key_debounce_4.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/key_debounce_4_if.sv
// Key bundle between the raw key pins and the debounced event outputs.
// The debouncer sits on the slave side; whoever drives the pins uses master.
interface key_debounce_4_if;
    logic [3:0] key;
    logic [3:0] key_value;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;

    modport master (
        output key,
        input  key_value,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key,
        output key_value,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/key_debounce_4.sv
// Four-channel push-button front end: two-flop synchroniser, one debounce FSM
// per key, registered level plus press, release and one-shot long-press pulses.
module key_debounce_4 #(
    parameter int DEB_CNT  = 1_000_000,
    parameter int LONG_CNT = 50_000_000
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    key_debounce_4_if.slave bus
);

    localparam int DW = $clog2(DEB_CNT);
    localparam int LW = $clog2(LONG_CNT);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CNT - 1);
    localparam logic [LW-1:0] LONG_SAT  = '1;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [3:0]    sync_1;
    logic [3:0]    key_s;

    state_t        state_q    [4];
    state_t        state_d    [4];
    logic [DW-1:0] deb_q      [4];
    logic [DW-1:0] deb_d      [4];
    logic [LW-1:0] long_cnt_q [4];
    logic [LW-1:0] long_cnt_d [4];

    logic [3:0]    fired_q,   fired_d;
    logic [3:0]    value_q,   value_d;
    logic [3:0]    press_q,   press_d;
    logic [3:0]    release_q, release_d;
    logic [3:0]    long_q,    long_d;

    // Flops reset to 1 so a key held through reset is seen as a fresh press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_1 <= 4'hF;
            key_s  <= 4'hF;
        end else begin
            sync_1 <= bus.key;
            key_s  <= sync_1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i]    <= IDLE;
                deb_q[i]      <= '0;
                long_cnt_q[i] <= '0;
            end
            fired_q   <= '0;
            value_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i]    <= state_d[i];
                deb_q[i]      <= deb_d[i];
                long_cnt_q[i] <= long_cnt_d[i];
            end
            fired_q   <= fired_d;
            value_q   <= value_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    // The long counter only advances in PRESSED, so release bounces freeze it.
    always_comb begin
        fired_d   = fired_q;
        value_d   = value_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i]    = state_q[i];
            deb_d[i]      = deb_q[i];
            long_cnt_d[i] = long_cnt_q[i];

            case (state_q[i])
                IDLE: begin
                    if (!key_s[i]) begin
                        state_d[i] = PRESS_WAIT;
                        deb_d[i]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (key_s[i]) begin
                        state_d[i] = IDLE;
                    end else if (deb_q[i] == DEB_LAST) begin
                        state_d[i]    = PRESSED;
                        value_d[i]    = 1'b1;
                        press_d[i]    = 1'b1;
                        long_cnt_d[i] = '0;
                        fired_d[i]    = 1'b0;
                    end else begin
                        deb_d[i] = deb_q[i] + 1'b1;
                    end
                end
                PRESSED: begin
                    if (key_s[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        deb_d[i]   = '0;
                    end else if (!fired_q[i] && long_cnt_q[i] == LONG_LAST) begin
                        long_d[i]  = 1'b1;
                        fired_d[i] = 1'b1;
                    end else if (long_cnt_q[i] != LONG_SAT) begin
                        long_cnt_d[i] = long_cnt_q[i] + 1'b1;
                    end
                end
                RELEASE_WAIT: begin
                    if (!key_s[i]) begin
                        state_d[i] = PRESSED;
                    end else if (deb_q[i] == DEB_LAST) begin
                        state_d[i]   = IDLE;
                        value_d[i]   = 1'b0;
                        release_d[i] = 1'b1;
                    end else begin
                        deb_d[i] = deb_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase
        end
    end

    assign bus.key_value   = value_q;
    assign bus.key_press   = press_q;
    assign bus.key_release = release_q;
    assign bus.key_long    = long_q;

endmodule
